mod_n_seq_ctrl: RTL and testbench
=================================

MOD_N_SEQ_CTRL -- requirements
Module: mod_n_seq_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the count width; modulus 0 encodes 2^WIDTH.
REQ-002 The block SHALL have parameter REPW, default 8, giving the repeat-counter width.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 cmd_valid  input  1  a command is offered.
REQ-007 cmd_ready  output  1  the block can accept a command.
REQ-008 cmd_mod  input  WIDTH  modulus of the run (count spans 0..mod-1).
REQ-009 cmd_reps  input  REPW  number of full modulus periods to run.
REQ-010 abort  input  1  terminates the active run.
REQ-011 pause  input  1  holds the run; functional only under PAUSE_EN.
REQ-012 count  output  WIDTH  current count value.
REQ-013 tc  output  1  terminal count, high in the cycle count equals mod-1 during RUN.
REQ-014 busy  output  1  high in RUN and PAUSE states.
REQ-015 done  output  1  one-cycle pulse on normal completion.
REQ-016 rep_left  output  REPW  periods remaining, including the current period.

Function
REQ-017 The FSM SHALL have states IDLE, RUN, PAUSE and DONE.
REQ-018 cmd_ready SHALL equal (state==IDLE && !rst), and a command SHALL be accepted on an edge with cmd_valid && cmd_ready.
REQ-019 On acceptance, the block SHALL latch cmd_mod and cmd_reps, set count=0 and rep_left=cmd_reps, and enter RUN at the next cycle.
REQ-020 If accepted cmd_reps=0, the block SHALL go directly to DONE with no tc, and count SHALL stay 0.
REQ-021 In RUN without pause, count SHALL increment by 1 per cycle and wrap to 0 on the edge after tc.
REQ-022 Mod 0 SHALL wrap at 2^WIDTH-1; mod 1 SHALL keep count=0 with tc high every RUN cycle.
REQ-023 tc SHALL be a combinational decode of the registered state: (state==RUN && count==mod-1).
REQ-024 On each tc edge, rep_left SHALL decrement; if rep_left was 1, the next state SHALL be DONE with count=0, otherwise RUN continues.
REQ-025 DONE SHALL last exactly one cycle with done=1, then return to IDLE; done SHALL be 0 in all other states.
REQ-026 abort in RUN or PAUSE SHALL move to IDLE on the next edge with count=0 and rep_left=0, and SHALL NOT raise done.
REQ-027 abort SHALL have priority over tc and pause; abort in IDLE or DONE SHALL be ignored, and a same-cycle command in IDLE SHALL still be accepted.
REQ-028 cmd_valid outside IDLE SHALL be ignored, and latched mod/reps SHALL NOT change mid-run.

Reset
REQ-029 On an edge with rst=1, the block SHALL enter IDLE with count=0, rep_left=0, latched mod=0 and latched reps=0, overriding every other input.
REQ-030 While rst=1, cmd_ready, tc, busy and done SHALL be 0; after the first edge with rst=0, cmd_ready SHALL be 1.
REQ-031 Reset asserted mid-run SHALL abandon the run without a done pulse.

Configuration
REQ-032 The block SHALL support the macro MOD_N_SEQ_CTRL_PAUSE_EN.
REQ-033 When MOD_N_SEQ_CTRL_PAUSE_EN is defined, pause=1 in RUN SHALL enter PAUSE, holding count and rep_left with tc=0; pause=0 in PAUSE SHALL return to RUN and resume counting from the held value.
REQ-034 When MOD_N_SEQ_CTRL_PAUSE_EN is undefined, the pause port SHALL exist but be ignored, and the PAUSE state SHALL be unreachable.

Verification
REQ-035 Bench scenario: mod=10, reps=2 accepted at edge E0 -> count runs 0..9 twice, tc at cycles 10 and 20 after E0, done=1 at cycle 21 only, cmd_ready=1 at cycle 22.
REQ-036 Bench scenario: mod=0, reps=1 -> count runs 0..15, a single tc at count=15, then DONE; mod=1, reps=3 -> tc high for 3 consecutive cycles, then done.
REQ-037 Bench scenario: reps=0 -> done one cycle after accept, with no tc and busy=0 throughout.
REQ-038 Bench scenario: abort at count=4 of period 1 (mod=10, reps=3) -> IDLE next cycle, count=0, rep_left=0, no done; abort coinciding with tc -> no rep decrement, no done.
REQ-039 Bench scenario: rst=1 at count=6 mid-run -> all outputs 0 the next cycle; cmd_valid held during RUN -> not accepted until IDLE.
REQ-040 Bench scenario with PAUSE_EN: pause for 3 cycles at count=5 -> count holds at 5 and tc=0, then resumes at 6, and done is delayed by exactly 3 cycles.

Source files
------------

// File: rtl/mod_n_seq_ctrl.sv
// Modulo-N run sequencer: counts 0..mod-1 for a commanded number of periods, then pulses done.
// Optional pause support is compiled in with the macro MOD_N_SEQ_CTRL_PAUSE_EN.
module mod_n_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int REPW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_mod,
  input  logic [REPW-1:0]  cmd_reps,
  input  logic             abort,
  input  logic             pause,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done,
  output logic [REPW-1:0]  rep_left
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [REPW-1:0]  REP_ONE = {{(REPW-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_next;
  logic [WIDTH-1:0] r_mod;
  logic [WIDTH-1:0] w_mod_next;
  logic [REPW-1:0]  r_rep;
  logic [REPW-1:0]  w_rep_next;
  logic [WIDTH-1:0] w_mod_m1;
  logic             w_last;
  logic             w_pause;

  // Modulus 0 naturally wraps to all-ones here, giving a full 2^WIDTH period.
  assign w_mod_m1 = r_mod - CNT_ONE;
  assign w_last   = (r_count == w_mod_m1);

`ifdef MOD_N_SEQ_CTRL_PAUSE_EN
  assign w_pause = pause;
`else
  logic w_pause_unused;
  assign w_pause_unused = pause;
  assign w_pause        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_mod   <= '0;
      r_rep   <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_mod   <= w_mod_next;
      r_rep   <= w_rep_next;
    end
  end

  // Leaving PAUSE performs the step that the pausing RUN cycle deferred, so a
  // pause taken on a terminal count still completes that period correctly.
  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_mod_next   = r_mod;
    w_rep_next   = r_rep;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_mod_next   = cmd_mod;
          w_rep_next   = cmd_reps;
          w_count_next = '0;
          w_state_next = (cmd_reps == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN, S_PAUSE: begin
        if (abort) begin
          w_state_next = S_IDLE;
          w_count_next = '0;
          w_rep_next   = '0;
        end else if (w_pause) begin
          w_state_next = S_PAUSE;
        end else if (w_last) begin
          w_count_next = '0;
          w_rep_next   = r_rep - REP_ONE;
          w_state_next = (r_rep == REP_ONE) ? S_DONE : S_RUN;
        end else begin
          w_count_next = r_count + CNT_ONE;
          w_state_next = S_RUN;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign cmd_ready = (r_state == S_IDLE) && !rst;
  assign tc        = !rst && (r_state == S_RUN) && w_last;
  assign busy      = !rst && ((r_state == S_RUN) || (r_state == S_PAUSE));
  assign done      = !rst && (r_state == S_DONE);
  assign count     = r_count;
  assign rep_left  = r_rep;

endmodule

// File: tb/tb_mod_n_seq_ctrl.sv
// Bench for mod_n_seq_ctrl: a per-cycle expected trace is built from the run rules
// (periods x modulus, then done) and compared against the observed outputs.
module tb_mod_n_seq_ctrl;

  typedef struct packed {
    logic [3:0] count;
    logic       tc;
    logic       busy;
    logic       done;
    logic       ready;
    logic [7:0] rep;
  } obs_t;

`ifdef MOD_N_SEQ_CTRL_PAUSE_EN
  localparam bit PAUSE_ON = 1'b1;
`else
  localparam bit PAUSE_ON = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_mod;
  logic [7:0] cmd_reps;
  logic       abort;
  logic       pause;
  logic [3:0] count;
  logic       tc;
  logic       busy;
  logic       done;
  logic [7:0] rep_left;

  int   n_checks;
  int   n_errors;
  obs_t exp_q[$];
  obs_t act_q[$];
  logic acc_ready;

  mod_n_seq_ctrl #(.WIDTH(4), .REPW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_mod   (cmd_mod),
    .cmd_reps  (cmd_reps),
    .abort     (abort),
    .pause     (pause),
    .count     (count),
    .tc        (tc),
    .busy      (busy),
    .done      (done),
    .rep_left  (rep_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t mk(input int c, input bit t, input bit b, input bit d,
                              input bit rd, input int rp);
    obs_t o;
    o.count = c[3:0];
    o.tc    = t;
    o.busy  = b;
    o.done  = d;
    o.ready = rd;
    o.rep   = rp[7:0];
    return o;
  endfunction

  function automatic obs_t idle_obs();
    return mk(0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.count = count;
    o.tc    = tc;
    o.busy  = busy;
    o.done  = done;
    o.ready = cmd_ready;
    o.rep   = rep_left;
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("cnt=%0d tc=%b busy=%b done=%b rdy=%b rep=%0d",
                     o.count, o.tc, o.busy, o.done, o.ready, o.rep);
  endfunction

  // Reference: reps periods of 0..M-1 with tc on the last value, then one done cycle.
  // A pause starting in a RUN cycle inserts held copies (tc low) after that cycle;
  // an abort in a busy cycle cuts the run, after which the block sits idle.
  task automatic build_model(input int m, input int r, input int pause_at,
                             input int pause_len, input int abort_at);
    int   big_m;
    obs_t e;
    big_m = (m == 0) ? 16 : m;
    exp_q.delete();
    for (int p = 0; p < r; p++)
      for (int c = 0; c < big_m; c++)
        exp_q.push_back(mk(c, c == big_m - 1, 1'b1, 1'b0, 1'b0, r - p));
    exp_q.push_back(mk(0, 1'b0, 1'b0, 1'b1, 1'b0, 0));
    if (PAUSE_ON && pause_at > 0 && pause_at <= exp_q.size()) begin
      if (exp_q[pause_at-1].busy) begin
        e    = exp_q[pause_at-1];
        e.tc = 1'b0;
        for (int k = 0; k < pause_len; k++) exp_q.insert(pause_at, e);
      end
    end
    if (abort_at > 0 && abort_at <= exp_q.size()) begin
      if (exp_q[abort_at-1].busy)
        while (exp_q.size() > abort_at) void'(exp_q.pop_back());
    end
  endtask

  function automatic obs_t exp_at(input int n);
    if (n >= 1 && n <= exp_q.size()) return exp_q[n-1];
    return idle_obs();
  endfunction

  // Offers one command (DUT assumed idle, called #1 after an edge) and records
  // the outputs of the ncyc cycles following the accept edge.
  task automatic run_cmd(input int m, input int r, input int pause_at, input int pause_len,
                         input int abort_at, input int ncyc, input bit hold_valid);
    cmd_mod   = m[3:0];
    cmd_reps  = r[7:0];
    cmd_valid = 1'b1;
    acc_ready = cmd_ready;
    @(posedge clk);
    #1;
    abort = 1'b0;
    if (hold_valid) begin
      cmd_mod  = cmd_mod ^ 4'd9;
      cmd_reps = cmd_reps + 8'd1;
    end else begin
      cmd_valid = 1'b0;
    end
    act_q.delete();
    for (int n = 1; n <= ncyc; n++) begin
      act_q.push_back(sample());
      abort = (n == abort_at);
      pause = (pause_at > 0) && (n >= pause_at) && (n < pause_at + pause_len);
      @(posedge clk);
      #1;
    end
    abort = 1'b0;
    pause = 1'b0;
    $display("cmd mod=%0d reps=%0d pause_at=%0d len=%0d abort_at=%0d cycles=%0d",
             m, r, pause_at, pause_len, abort_at, ncyc);
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    cmd_valid = 1'b1;
    cmd_mod   = 4'd3;
    cmd_reps  = 8'd2;
    abort     = 1'b0;
    pause     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (sample() !== mk(0, 0, 0, 0, 0, 0)) begin
      n_errors++;
      $display("FAIL reset_hold: got %s, want all zero", fmt(sample()));
    end
    cmd_valid = 1'b0;
    rst       = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (sample() !== idle_obs()) begin
      n_errors++;
      $display("FAIL reset_release: got %s, want %s", fmt(sample()), fmt(idle_obs()));
    end
  endtask

  task automatic test_basic();
    build_model(10, 2, 0, 0, 0);
    run_cmd(10, 2, 0, 0, 0, exp_q.size() + 2, 1'b0);
    n_checks++;
    if (acc_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL basic_accept_ready: got %b, want 1", acc_ready);
    end
    for (int n = 1; n <= act_q.size(); n++) begin
      n_checks++;
      if (act_q[n-1] !== exp_at(n)) begin
        n_errors++;
        $display("FAIL basic cyc %0d: got %s, want %s", n, fmt(act_q[n-1]), fmt(exp_at(n)));
      end
    end
    n_checks++;
    if ({act_q[9].tc, act_q[19].tc, act_q[20].done, act_q[21].ready, act_q[21].done} !== 5'b11110) begin
      n_errors++;
      $display("FAIL basic_milestones: got tc10=%b tc20=%b done21=%b rdy22=%b done22=%b, want 1 1 1 1 0",
               act_q[9].tc, act_q[19].tc, act_q[20].done, act_q[21].ready, act_q[21].done);
    end
  endtask

  task automatic test_mod_edges();
    build_model(0, 1, 0, 0, 0);
    run_cmd(0, 1, 0, 0, 0, exp_q.size() + 2, 1'b0);
    for (int n = 1; n <= act_q.size(); n++) begin
      n_checks++;
      if (act_q[n-1] !== exp_at(n)) begin
        n_errors++;
        $display("FAIL mod0 cyc %0d: got %s, want %s", n, fmt(act_q[n-1]), fmt(exp_at(n)));
      end
    end
    build_model(1, 3, 0, 0, 0);
    run_cmd(1, 3, 0, 0, 0, exp_q.size() + 2, 1'b0);
    for (int n = 1; n <= act_q.size(); n++) begin
      n_checks++;
      if (act_q[n-1] !== exp_at(n)) begin
        n_errors++;
        $display("FAIL mod1 cyc %0d: got %s, want %s", n, fmt(act_q[n-1]), fmt(exp_at(n)));
      end
    end
  endtask

  task automatic test_zero_reps();
    build_model(7, 0, 0, 0, 0);
    run_cmd(7, 0, 0, 0, 0, 3, 1'b0);
    for (int n = 1; n <= act_q.size(); n++) begin
      n_checks++;
      if (act_q[n-1] !== exp_at(n)) begin
        n_errors++;
        $display("FAIL zero_reps cyc %0d: got %s, want %s", n, fmt(act_q[n-1]), fmt(exp_at(n)));
      end
    end
  endtask

  task automatic test_abort();
    // abort at count 4 of the first period, abort on a tc, abort in DONE (ignored)
    int cases[3][3] = '{'{10, 3, 5}, '{10, 3, 10}, '{3, 1, 4}};
    for (int k = 0; k < 3; k++) begin
      build_model(cases[k][0], cases[k][1], 0, 0, cases[k][2]);
      run_cmd(cases[k][0], cases[k][1], 0, 0, cases[k][2], exp_q.size() + 3, 1'b0);
      for (int n = 1; n <= act_q.size(); n++) begin
        n_checks++;
        if (act_q[n-1] !== exp_at(n)) begin
          n_errors++;
          $display("FAIL abort%0d cyc %0d: got %s, want %s", k, n, fmt(act_q[n-1]), fmt(exp_at(n)));
        end
      end
    end
    // abort asserted in IDLE together with a command: the command still goes in
    abort = 1'b1;
    build_model(4, 1, 0, 0, 0);
    run_cmd(4, 1, 0, 0, 0, exp_q.size() + 2, 1'b0);
    for (int n = 1; n <= act_q.size(); n++) begin
      n_checks++;
      if (act_q[n-1] !== exp_at(n)) begin
        n_errors++;
        $display("FAIL abort_idle cyc %0d: got %s, want %s", n, fmt(act_q[n-1]), fmt(exp_at(n)));
      end
    end
  endtask

  task automatic test_reset_mid_run();
    run_cmd(10, 2, 0, 0, 0, 6, 1'b0);
    n_checks++;
    if (sample() !== mk(6, 0, 1, 0, 0, 2)) begin
      n_errors++;
      $display("FAIL rst_mid_pre: got %s, want %s", fmt(sample()), fmt(mk(6, 0, 1, 0, 0, 2)));
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (sample() !== mk(0, 0, 0, 0, 0, 0)) begin
      n_errors++;
      $display("FAIL rst_mid_zero: got %s, want all zero", fmt(sample()));
    end
    rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (sample() !== idle_obs()) begin
        n_errors++;
        $display("FAIL rst_mid_after %0d: got %s, want %s", n, fmt(sample()), fmt(idle_obs()));
      end
    end
  endtask

  task automatic test_back_to_back();
    build_model(5, 2, 0, 0, 0);
    run_cmd(5, 2, 0, 0, 0, exp_q.size() + 1, 1'b1);
    for (int n = 1; n <= act_q.size(); n++) begin
      n_checks++;
      if (act_q[n-1] !== exp_at(n)) begin
        n_errors++;
        $display("FAIL hold_valid cyc %0d: got %s, want %s", n, fmt(act_q[n-1]), fmt(exp_at(n)));
      end
    end
    cmd_valid = 1'b0;
    n_checks++;
    if (sample() !== mk(0, 0, 1, 0, 0, 3)) begin
      n_errors++;
      $display("FAIL hold_valid_reaccept: got %s, want %s", fmt(sample()), fmt(mk(0, 0, 1, 0, 0, 3)));
    end
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    n_checks++;
    if (sample() !== idle_obs()) begin
      n_errors++;
      $display("FAIL hold_valid_abort: got %s, want %s", fmt(sample()), fmt(idle_obs()));
    end
  endtask

  task automatic test_pause();
    build_model(10, 2, 6, 3, 0);
    run_cmd(10, 2, 6, 3, 0, exp_q.size() + 2, 1'b0);
    for (int n = 1; n <= act_q.size(); n++) begin
      n_checks++;
      if (act_q[n-1] !== exp_at(n)) begin
        n_errors++;
        $display("FAIL pause cyc %0d: got %s, want %s", n, fmt(act_q[n-1]), fmt(exp_at(n)));
      end
    end
    n_checks++;
    if (act_q[8].count !== 4'd5 || act_q[8].tc !== 1'b0 || act_q[9].count !== 4'd6 ||
        act_q[23].done !== 1'b1 || act_q[20].done !== 1'b0) begin
      n_errors++;
      $display("FAIL pause_milestones: got cnt9=%0d tc9=%b cnt10=%0d done24=%b done21=%b, want 5 0 6 1 0",
               act_q[8].count, act_q[8].tc, act_q[9].count, act_q[23].done, act_q[20].done);
    end
  endtask

  task automatic test_random();
    int m, r, pa, pl, ab;
    for (int it = 0; it < 25; it++) begin
      m  = $urandom_range(0, 15);
      r  = $urandom_range(0, 3);
      pa = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 40);
      pl = $urandom_range(1, 4);
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 50) : 0;
      build_model(m, r, pa, pl, ab);
      run_cmd(m, r, pa, pl, ab, exp_q.size() + 2, 1'b0);
      n_checks++;
      if (acc_ready !== 1'b1) begin
        n_errors++;
        $display("FAIL rand%0d accept_ready: got %b, want 1", it, acc_ready);
      end
      for (int n = 1; n <= act_q.size(); n++) begin
        n_checks++;
        if (act_q[n-1] !== exp_at(n)) begin
          n_errors++;
          $display("FAIL rand%0d cyc %0d: got %s, want %s", it, n, fmt(act_q[n-1]), fmt(exp_at(n)));
        end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_basic();
    test_mod_edges();
    test_zero_reps();
    test_abort();
    test_reset_mid_run();
    test_back_to_back();
`ifdef MOD_N_SEQ_CTRL_PAUSE_EN
    test_pause();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
